// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer and the datapath / program counter.
// The sequencer takes the slave view; the datapath side takes the master view.
interface fetch_sequencer_if;
    logic        run;
    logic [7:0]  rom_data;
    logic        carry;
    logic        hold;
    logic        pc_en;
    logic        pc_load;
    logic [11:0] pc_value;
    logic [7:0]  ir;
    logic        exec_strobe;
    logic        halted;
    logic [2:0]  state;

    modport slave (
        input  run, rom_data, carry, hold,
        output pc_en, pc_load, pc_value, ir, exec_strobe, halted, state
    );

    modport master (
        output run, rom_data, carry, hold,
        input  pc_en, pc_load, pc_value, ir, exec_strobe, halted, state
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode sequencer: walks FETCH, DECODE, optional OPERAND and EXECUTE,
// issuing program-counter increment/load requests and the datapath execute qualifier.
module fetch_sequencer #(
    parameter logic [3:0] OP_JC   = 4'hD,
    parameter logic [3:0] OP_JMP  = 4'hE,
    parameter logic [3:0] OP_HALT = 4'hF
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        OPERAND = 3'd3,
        EXECUTE = 3'd4,
        HALTED  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] operand_q, operand_d;
    logic [3:0] pc_hi_q, pc_hi_d;
    logic       take_q, take_d;
    logic [3:0] opcode;

    assign opcode = ir_q[7:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ir_q      <= 8'h00;
            operand_q <= 8'h00;
            pc_hi_q   <= 4'h0;
            take_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            operand_q <= operand_d;
            pc_hi_q   <= pc_hi_d;
            take_q    <= take_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        operand_d = operand_q;
        pc_hi_d   = pc_hi_q;
        take_d    = take_q;
        case (state_q)
            IDLE: begin
                if (bus.run) state_d = FETCH;
            end
            FETCH: begin
                ir_d    = bus.rom_data;
                state_d = DECODE;
            end
            DECODE: begin
                if (opcode == OP_JMP || opcode == OP_JC) begin
                    state_d = OPERAND;
                end else if (opcode == OP_HALT) begin
                    state_d = HALTED;
                end else begin
                    take_d  = 1'b0;
                    state_d = EXECUTE;
                end
            end
            OPERAND: begin
                // Target high nibble is latched with the operand so pc_value holds between jumps.
                operand_d = bus.rom_data;
                pc_hi_d   = ir_q[3:0];
                take_d    = (opcode == OP_JMP) || ((opcode == OP_JC) && bus.carry);
                state_d   = EXECUTE;
            end
            EXECUTE: begin
                // Clearing take after the first cycle keeps pc_load a single pulse under hold.
                take_d = 1'b0;
                if (!bus.hold) state_d = bus.run ? FETCH : IDLE;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pc_en       = (state_q == FETCH) || (state_q == OPERAND);
    assign bus.pc_load     = (state_q == EXECUTE) && take_q;
    assign bus.exec_strobe = (state_q == EXECUTE);
    assign bus.halted      = (state_q == HALTED);
    assign bus.state       = state_q;
    assign bus.ir          = ir_q;
    assign bus.pc_value    = {pc_hi_q, operand_q};

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a program ROM and program counter surround the DUT, and each
// instruction is predicted from the opcode rules (state trace, pulse counts, next PC).
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  rom [0:4095];
    logic [11:0] pc_q;

    fetch_sequencer_if bus();

    fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = rom[pc_q];

    always @(posedge clk or posedge reset) begin
        if (reset)              pc_q <= 12'h000;
        else if (bus.pc_load)   pc_q <= bus.pc_value;
        else if (bus.pc_en)     pc_q <= pc_q + 12'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pc_en"},   32'(bus.pc_en), 0);
        check({tag, "_pc_load"}, 32'(bus.pc_load), 0);
        check({tag, "_exec"},    32'(bus.exec_strobe), 0);
    endtask

    // Runs one instruction starting with the DUT sampled in FETCH and compares against the
    // outcome implied by the opcode: state trace, pulse counts, latency, captured ir, next PC.
    task automatic exec_one(input int holds, input bit cy, input bit drop_run);
        logic [11:0] p;
        logic [7:0]  ins;
        logic [3:0]  op;
        logic [11:0] target;
        logic [11:0] exp_pc;
        bit          is_jmp, is_halt, taken;
        int          exp_q[$];
        int          exp_cyc, exp_en, exp_ld, exp_ex, exp_end;
        int          cyc, n_en, n_ld, n_ex, k;
        int          s;

        p       = pc_q;
        ins     = rom[p];
        op      = ins[7:4];
        is_jmp  = (op == 4'hE) || (op == 4'hD);
        is_halt = (op == 4'hF);
        taken   = (op == 4'hE) || ((op == 4'hD) && cy);
        target  = {ins[3:0], rom[p + 12'd1]};

        exp_q.push_back(1);
        exp_q.push_back(2);
        if (is_jmp) exp_q.push_back(3);
        if (!is_halt) for (int i = 0; i <= holds; i++) exp_q.push_back(4);

        exp_cyc = is_halt ? 2 : (is_jmp ? 4 : 3) + holds;
        exp_en  = is_jmp ? 2 : 1;
        exp_ld  = taken ? 1 : 0;
        exp_ex  = is_halt ? 0 : holds + 1;
        exp_end = is_halt ? 5 : (drop_run ? 0 : 1);
        exp_pc  = taken ? target : p + (is_jmp ? 12'd2 : 12'd1);

        bus.carry = cy;
        cyc = 0; n_en = 0; n_ld = 0; n_ex = 0; k = 0;
        do begin
            s = (exp_q.size() > 0) ? exp_q.pop_front() : 7;
            check("state_trace", 32'(bus.state), s);
            check("en_ld_exclusive", 32'(bus.pc_en & bus.pc_load), 0);
            check("halted_low", 32'(bus.halted), 0);
            if (bus.pc_en) n_en++;
            if (bus.exec_strobe) n_ex++;
            if (bus.pc_load) begin
                n_ld++;
                check("pc_value", 32'(bus.pc_value), 32'(target));
            end
            if (bus.state == 3'd4) begin
                k++;
                bus.hold = (k <= holds);
                if (drop_run) bus.run = 1'b0;
            end else begin
                bus.hold = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end while ((bus.state == 3'd2 || bus.state == 3'd3 || bus.state == 3'd4) && cyc < 40);
        bus.hold = 1'b0;

        check("latency", cyc, exp_cyc);
        check("pc_en_count", n_en, exp_en);
        check("pc_load_count", n_ld, exp_ld);
        check("exec_count", n_ex, exp_ex);
        check("end_state", 32'(bus.state), exp_end);
        check("ir", 32'(bus.ir), 32'(ins));
        check("next_pc", 32'(pc_q), 32'(exp_pc));
    endtask

    initial begin
        logic [7:0] b;

        for (int i = 0; i < 4096; i++) begin
            b = 8'($urandom);
            if (b[7:4] == 4'hF) b[7:4] = 4'h1;
            rom[i] = b;
        end
        rom[12'h000] = 8'h12;
        rom[12'h001] = 8'hE3; rom[12'h002] = 8'h45;
        rom[12'h345] = 8'hD7; rom[12'h346] = 8'h80;
        rom[12'h347] = 8'hD7; rom[12'h348] = 8'h80;
        rom[12'h780] = 8'h31;
        rom[12'h781] = 8'hE5; rom[12'h782] = 8'h00;
        rom[12'h500] = 8'h27;

        reset = 1'b1;
        bus.run = 1'b0; bus.carry = 1'b0; bus.hold = 1'b0;
        tick(); tick();
        check("rst_state", 32'(bus.state), 0);
        check("rst_ir", 32'(bus.ir), 0);
        check("rst_pc_value", 32'(bus.pc_value), 0);
        check("rst_halted", 32'(bus.halted), 0);
        check_quiet("rst");
        reset = 1'b0;

        tick();
        check("idle_wait", 32'(bus.state), 0);
        bus.run = 1'b1;
        tick();
        check("start_fetch", 32'(bus.state), 1);

        exec_one(0, 1'b0, 1'b0);   // 12: plain instruction
        exec_one(0, 1'b0, 1'b0);   // E3 45: jump to 345
        exec_one(0, 1'b0, 1'b0);   // D7 80, carry 0: not taken
        exec_one(0, 1'b1, 1'b0);   // D7 80, carry 1: jump to 780
        exec_one(3, 1'b0, 1'b0);   // 31 held three cycles
        exec_one(2, 1'b1, 1'b0);   // E5 00 held: single pc_load
        exec_one(1, 1'b0, 1'b1);   // 27 with run dropped during EXECUTE

        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_after_drop", 32'(bus.state), 0);
            check("pc_frozen", 32'(pc_q), 32'h501);
            check_quiet("idle");
        end
        bus.run = 1'b1;
        tick();
        check("restart_fetch", 32'(bus.state), 1);

        for (int i = 0; i < 40; i++)
            exec_one(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);

        rom[12'h000] = 8'hE1; rom[12'h001] = 8'h23;
        bus.run = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        check("post_rst_idle", 32'(bus.state), 0);
        bus.run = 1'b1;
        tick();
        check("op_fetch", 32'(bus.state), 1);
        tick();
        check("op_decode", 32'(bus.state), 2);
        tick();
        check("op_operand", 32'(bus.state), 3);
        #2 reset = 1'b1;
        #1;
        check("async_state", 32'(bus.state), 0);
        check("async_ir", 32'(bus.ir), 0);
        check("async_pc_value", 32'(bus.pc_value), 0);
        check("async_halted", 32'(bus.halted), 0);
        check_quiet("async");
        tick();
        check("rst_hold_load", 32'(bus.pc_load), 0);
        check("rst_hold_state", 32'(bus.state), 0);

        rom[12'h000] = 8'hF0;
        reset = 1'b0;
        tick();
        check("halt_fetch", 32'(bus.state), 1);
        exec_one(0, 1'b0, 1'b0);
        check("halted_flag", 32'(bus.halted), 1);
        for (int i = 0; i < 6; i++) begin
            bus.run  = 1'($urandom_range(0, 1));
            bus.hold = 1'($urandom_range(0, 1));
            tick();
            check("halt_persist", 32'(bus.state), 5);
            check("halt_flag_persist", 32'(bus.halted), 1);
            check_quiet("halt");
        end
        reset = 1'b1;
        #1;
        check("halt_rst_state", 32'(bus.state), 0);
        check("halt_rst_flag", 32'(bus.halted), 0);
        reset = 1'b0;
        bus.run = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
